// File: rtl/cp0_exc_unit.sv
// CP0 precise-exception unit: fixed-priority cause selection, pipeline flush/redirect,
// and the Status/Cause/EPC/BadVAddr/Count/Compare registers with mfc0/mtc0 access.
module cp0_exc_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] pc,
    input  logic        in_delay_slot,
    input  logic        eret_flag,
    input  logic        syscall_flag,
    input  logic        break_flag,
    input  logic        ri_flag,
    input  logic        ov_flag,
    input  logic        adel_if,
    input  logic        adel_mem,
    input  logic        ades_mem,
    input  logic [31:0] mem_addr,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [4:0]  cp0_raddr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic [31:0] exc_pc,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc
);

    localparam logic [31:0] EXC_ENTRY    = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;

    logic [31:0] status_r;
    logic [31:0] epc_r;
    logic [31:0] badvaddr_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        tick_r;
    logic        bd_r;
    logic        ti_r;
    logic [7:0]  ip_r;
    logic [4:0]  exc_code_r;

    logic        int_req_s;
    logic        any_exc_s;
    logic        exc_s;
    logic        eret_s;
    logic        wr_ok_s;
    logic [4:0]  code_s;
    logic        bad_we_s;
    logic [31:0] bad_addr_s;

    assign int_req_s = status_r[0] & ~status_r[1] & (|(ip_r & status_r[15:8]));
    assign any_exc_s = int_req_s | adel_if | ri_flag | ov_flag | syscall_flag
                     | break_flag | adel_mem | ades_mem;
    assign exc_s     = valid & any_exc_s;
    assign eret_s    = valid & eret_flag & ~any_exc_s;
    // A same-cycle exception or eret squashes the mtc0 that rides with it.
    assign wr_ok_s   = cp0_we & ~exc_s & ~eret_s;

    assign flush  = (exc_s | eret_s) & ~rst;
    assign exc_pc = eret_s ? epc_r : EXC_ENTRY;
    assign status = status_r;
    assign cause  = {bd_r, ti_r, 14'd0, ip_r, 1'b0, exc_code_r, 2'b00};
    assign epc    = epc_r;

    // Fixed-priority cause selection and BadVAddr source.
    always_comb begin
        code_s     = 5'd0;
        bad_we_s   = 1'b0;
        bad_addr_s = pc;
        if (int_req_s) begin
            code_s = 5'd0;
        end else if (adel_if) begin
            code_s   = 5'd4;
            bad_we_s = 1'b1;
        end else if (ri_flag) begin
            code_s = 5'd10;
        end else if (ov_flag) begin
            code_s = 5'd12;
        end else if (syscall_flag) begin
            code_s = 5'd8;
        end else if (break_flag) begin
            code_s = 5'd9;
        end else if (adel_mem) begin
            code_s     = 5'd4;
            bad_we_s   = 1'b1;
            bad_addr_s = mem_addr;
        end else if (ades_mem) begin
            code_s     = 5'd5;
            bad_we_s   = 1'b1;
            bad_addr_s = mem_addr;
        end else begin
            code_s = 5'd0;
        end
    end

    // mfc0 read mux, reflecting registered state only.
    always_comb begin
        case (cp0_raddr)
            REG_BADVADDR: cp0_rdata = badvaddr_r;
            REG_COUNT:    cp0_rdata = count_r;
            REG_COMPARE:  cp0_rdata = compare_r;
            REG_STATUS:   cp0_rdata = status_r;
            REG_CAUSE:    cp0_rdata = cause;
            REG_EPC:      cp0_rdata = epc_r;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    // Count/Compare timer and the sticky TI flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_r    <= 1'b0;
            count_r   <= 32'd0;
            compare_r <= 32'd0;
            ti_r      <= 1'b0;
        end else begin
            tick_r <= ~tick_r;
            if (wr_ok_s && (cp0_waddr == REG_COUNT)) begin
                count_r <= cp0_wdata;
            end else if (tick_r) begin
                count_r <= count_r + 32'd1;
            end
            if (wr_ok_s && (cp0_waddr == REG_COMPARE)) begin
                compare_r <= cp0_wdata;
                ti_r      <= 1'b0;
            end else if ((count_r == compare_r) && (compare_r != 32'd0)) begin
                ti_r <= 1'b1;
            end
        end
    end

    // Exception/eret side effects and mtc0 writes to Status, Cause and EPC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_r   <= STATUS_RESET;
            epc_r      <= 32'd0;
            badvaddr_r <= 32'd0;
            bd_r       <= 1'b0;
            ip_r       <= 8'd0;
            exc_code_r <= 5'd0;
        end else begin
            ip_r[7:2] <= {hw_int[5] | ti_r, hw_int[4:0]};
            if (exc_s) begin
                status_r   <= status_r | 32'h0000_0002;
                exc_code_r <= code_s;
                if (!status_r[1]) begin
                    bd_r  <= in_delay_slot;
                    epc_r <= in_delay_slot ? (pc - 32'd4) : pc;
                end
                if (bad_we_s) begin
                    badvaddr_r <= bad_addr_s;
                end
            end else if (eret_s) begin
                status_r <= status_r & ~32'h0000_0002;
            end else if (wr_ok_s) begin
                case (cp0_waddr)
                    REG_STATUS: status_r  <= (status_r & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
                    REG_CAUSE:  ip_r[1:0] <= cp0_wdata[9:8];
                    REG_EPC:    epc_r     <= cp0_wdata;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard-driven bench for cp0_exc_unit: expectations are queued when stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_cp0_exc_unit;

    localparam logic [31:0] ENTRY = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, in_delay_slot;
    logic [31:0] pc, mem_addr;
    logic        eret_flag, syscall_flag, break_flag, ri_flag, ov_flag;
    logic        adel_if, adel_mem, ades_mem;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr, cp0_raddr;
    logic [31:0] cp0_wdata, cp0_rdata;
    logic        flush;
    logic [31:0] exc_pc, status, cause, epc;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    cp0_exc_unit dut (
        .clk(clk), .rst(rst), .valid(valid), .pc(pc), .in_delay_slot(in_delay_slot),
        .eret_flag(eret_flag), .syscall_flag(syscall_flag), .break_flag(break_flag),
        .ri_flag(ri_flag), .ov_flag(ov_flag), .adel_if(adel_if), .adel_mem(adel_mem),
        .ades_mem(ades_mem), .mem_addr(mem_addr), .hw_int(hw_int), .cp0_we(cp0_we),
        .cp0_waddr(cp0_waddr), .cp0_raddr(cp0_raddr), .cp0_wdata(cp0_wdata),
        .cp0_rdata(cp0_rdata), .flush(flush), .exc_pc(exc_pc), .status(status),
        .cause(cause), .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        valid = 1'b0; in_delay_slot = 1'b0; pc = 32'd0; mem_addr = 32'd0;
        eret_flag = 1'b0; syscall_flag = 1'b0; break_flag = 1'b0; ri_flag = 1'b0;
        ov_flag = 1'b0; adel_if = 1'b0; adel_mem = 1'b0; ades_mem = 1'b0;
        hw_int = 6'd0; cp0_we = 1'b0; cp0_waddr = 5'd0; cp0_wdata = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0_we = 1'b1; cp0_waddr = addr; cp0_wdata = data;
        step();
        cp0_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        cp0_raddr = 5'd9;
        #2;
        valid = 1'b1; syscall_flag = 1'b1; pc = 32'hBFC0_1000;
        exp_q.push_back(32'd0);
        #1;
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, flush} !== exp_v) begin failures++; $display("FAIL rst_flush got=%h exp=%h", flush, exp_v); end
        step(); step();
        clear_inputs();
        rst = 1'b0;
        exp_q.push_back(32'h0040_0000); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        checks++; exp_v = exp_q.pop_front();
        if (status !== exp_v) begin failures++; $display("FAIL rst_status got=%h exp=%h", status, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (cause !== exp_v) begin failures++; $display("FAIL rst_cause got=%h exp=%h", cause, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (epc !== exp_v) begin failures++; $display("FAIL rst_epc got=%h exp=%h", epc, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (cp0_rdata !== exp_v) begin failures++; $display("FAIL rst_count got=%h exp=%h", cp0_rdata, exp_v); end
    endtask

    task automatic test_syscall();
        valid = 1'b1; syscall_flag = 1'b1; pc = 32'hBFC0_1000;
        exp_q.push_back(32'd1); exp_q.push_back(ENTRY);
        exp_q.push_back(32'hBFC0_1000); exp_q.push_back(32'd8); exp_q.push_back(32'd1);
        #1;
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, flush} !== exp_v) begin failures++; $display("FAIL sys_flush got=%h exp=%h", flush, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (exc_pc !== exp_v) begin failures++; $display("FAIL sys_exc_pc got=%h exp=%h", exc_pc, exp_v); end
        step();
        clear_inputs();
        checks++; exp_v = exp_q.pop_front();
        if (epc !== exp_v) begin failures++; $display("FAIL sys_epc got=%h exp=%h", epc, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if ({27'd0, cause[6:2]} !== exp_v) begin failures++; $display("FAIL sys_code got=%h exp=%h", cause[6:2], exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, status[1]} !== exp_v) begin failures++; $display("FAIL sys_exl got=%h exp=%h", status[1], exp_v); end
        valid = 1'b1; eret_flag = 1'b1;
        exp_q.push_back(32'hBFC0_1000); exp_q.push_back(32'd0);
        #1;
        checks++; exp_v = exp_q.pop_front();
        if (exc_pc !== exp_v) begin failures++; $display("FAIL sys_eret_pc got=%h exp=%h", exc_pc, exp_v); end
        step();
        clear_inputs();
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, status[1]} !== exp_v) begin failures++; $display("FAIL sys_eret_exl got=%h exp=%h", status[1], exp_v); end
    endtask

    task automatic test_break_eret();
        valid = 1'b1; break_flag = 1'b1; in_delay_slot = 1'b1; pc = 32'hBFC0_2004;
        exp_q.push_back(32'hBFC0_2000); exp_q.push_back(32'd1); exp_q.push_back(32'd9);
        step();
        clear_inputs();
        checks++; exp_v = exp_q.pop_front();
        if (epc !== exp_v) begin failures++; $display("FAIL brk_epc got=%h exp=%h", epc, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, cause[31]} !== exp_v) begin failures++; $display("FAIL brk_bd got=%h exp=%h", cause[31], exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if ({27'd0, cause[6:2]} !== exp_v) begin failures++; $display("FAIL brk_code got=%h exp=%h", cause[6:2], exp_v); end
        valid = 1'b1; eret_flag = 1'b1;
        exp_q.push_back(32'd1); exp_q.push_back(32'hBFC0_2000); exp_q.push_back(32'd0);
        #1;
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, flush} !== exp_v) begin failures++; $display("FAIL eret_flush got=%h exp=%h", flush, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (exc_pc !== exp_v) begin failures++; $display("FAIL eret_pc got=%h exp=%h", exc_pc, exp_v); end
        step();
        clear_inputs();
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, status[1]} !== exp_v) begin failures++; $display("FAIL eret_exl got=%h exp=%h", status[1], exp_v); end
    endtask

    task automatic test_priority();
        valid = 1'b1; ri_flag = 1'b1; ov_flag = 1'b1; syscall_flag = 1'b1; pc = 32'hBFC0_3000;
        exp_q.push_back(32'd10);
        step();
        clear_inputs();
        checks++; exp_v = exp_q.pop_front();
        if ({27'd0, cause[6:2]} !== exp_v) begin failures++; $display("FAIL prio_ri got=%h exp=%h", cause[6:2], exp_v); end
        mtc0(5'd12, 32'd0);
        cp0_raddr = 5'd8;
        valid = 1'b1; adel_if = 1'b1; ri_flag = 1'b1; ov_flag = 1'b1; syscall_flag = 1'b1; pc = 32'hBFC0_3001;
        exp_q.push_back(32'd4); exp_q.push_back(32'hBFC0_3001);
        step();
        clear_inputs();
        checks++; exp_v = exp_q.pop_front();
        if ({27'd0, cause[6:2]} !== exp_v) begin failures++; $display("FAIL prio_adel got=%h exp=%h", cause[6:2], exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (cp0_rdata !== exp_v) begin failures++; $display("FAIL prio_badv got=%h exp=%h", cp0_rdata, exp_v); end
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_ades_mtc0();
        cp0_raddr = 5'd8;
        valid = 1'b1; ades_mem = 1'b1; mem_addr = 32'h8000_0003; pc = 32'hBFC0_4000;
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h1234_5678;
        exp_q.push_back(32'd5); exp_q.push_back(32'h8000_0003); exp_q.push_back(32'hBFC0_4000);
        step();
        clear_inputs();
        checks++; exp_v = exp_q.pop_front();
        if ({27'd0, cause[6:2]} !== exp_v) begin failures++; $display("FAIL ades_code got=%h exp=%h", cause[6:2], exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (cp0_rdata !== exp_v) begin failures++; $display("FAIL ades_badv got=%h exp=%h", cp0_rdata, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (epc !== exp_v) begin failures++; $display("FAIL ades_epc_discard got=%h exp=%h", epc, exp_v); end
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_back_to_back();
        valid = 1'b1; syscall_flag = 1'b1; pc = 32'hBFC0_5000;
        step();
        clear_inputs();
        valid = 1'b1; break_flag = 1'b1; in_delay_slot = 1'b1; pc = 32'hBFC0_6004;
        exp_q.push_back(32'd1); exp_q.push_back(32'hBFC0_5000); exp_q.push_back(32'd9);
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        #1;
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, flush} !== exp_v) begin failures++; $display("FAIL nest_flush got=%h exp=%h", flush, exp_v); end
        step();
        clear_inputs();
        checks++; exp_v = exp_q.pop_front();
        if (epc !== exp_v) begin failures++; $display("FAIL nest_epc got=%h exp=%h", epc, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if ({27'd0, cause[6:2]} !== exp_v) begin failures++; $display("FAIL nest_code got=%h exp=%h", cause[6:2], exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, cause[31]} !== exp_v) begin failures++; $display("FAIL nest_bd got=%h exp=%h", cause[31], exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, status[1]} !== exp_v) begin failures++; $display("FAIL nest_exl got=%h exp=%h", status[1], exp_v); end
    endtask

    task automatic test_mtc0_rw();
        cp0_raddr = 5'd14;
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h1234_5678;
        exp_q.push_back(32'hBFC0_5000); exp_q.push_back(32'h1234_5678);
        #1;
        checks++; exp_v = exp_q.pop_front();
        if (cp0_rdata !== exp_v) begin failures++; $display("FAIL mtc0_noforward got=%h exp=%h", cp0_rdata, exp_v); end
        step();
        cp0_we = 1'b0;
        checks++; exp_v = exp_q.pop_front();
        if (cp0_rdata !== exp_v) begin failures++; $display("FAIL mtc0_epc got=%h exp=%h", cp0_rdata, exp_v); end
        exp_q.push_back(32'h0000_0324);
        mtc0(5'd13, 32'hFFFF_FFFF);
        checks++; exp_v = exp_q.pop_front();
        if ((cause & 32'hC000_037C) !== exp_v) begin failures++; $display("FAIL mtc0_cause got=%h exp=%h", cause, exp_v); end
        exp_q.push_back(32'h0040_FF03);
        mtc0(5'd12, 32'hFFFF_FFFF);
        checks++; exp_v = exp_q.pop_front();
        if (status !== exp_v) begin failures++; $display("FAIL mtc0_status got=%h exp=%h", status, exp_v); end
        mtc0(5'd12, 32'd0);
        mtc0(5'd13, 32'd0);
    endtask

    task automatic test_timer();
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd10);
        mtc0(5'd12, 32'h0000_8001);
        exp_q.push_back(32'd1);
        for (int i = 0; i < 60 && !cause[30]; i++) step();
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, cause[30]} !== exp_v) begin failures++; $display("FAIL timer_ti got=%h exp=%h", cause[30], exp_v); end
        exp_q.push_back(32'd1);
        step();
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, cause[15]} !== exp_v) begin failures++; $display("FAIL timer_ip7 got=%h exp=%h", cause[15], exp_v); end
        valid = 1'b1; pc = 32'hBFC0_7000;
        exp_q.push_back(32'd1); exp_q.push_back(ENTRY); exp_q.push_back(32'd0); exp_q.push_back(32'hBFC0_7000);
        #1;
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, flush} !== exp_v) begin failures++; $display("FAIL timer_flush got=%h exp=%h", flush, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (exc_pc !== exp_v) begin failures++; $display("FAIL timer_exc_pc got=%h exp=%h", exc_pc, exp_v); end
        step();
        clear_inputs();
        checks++; exp_v = exp_q.pop_front();
        if ({27'd0, cause[6:2]} !== exp_v) begin failures++; $display("FAIL timer_code got=%h exp=%h", cause[6:2], exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (epc !== exp_v) begin failures++; $display("FAIL timer_epc got=%h exp=%h", epc, exp_v); end
        exp_q.push_back(32'd0);
        mtc0(5'd11, 32'd0);
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, cause[30]} !== exp_v) begin failures++; $display("FAIL timer_ti_clear got=%h exp=%h", cause[30], exp_v); end
    endtask

    task automatic test_async_reset();
        cp0_raddr = 5'd9;
        valid = 1'b1; syscall_flag = 1'b1; pc = 32'hBFC0_8000;
        exp_q.push_back(32'd1);
        #1;
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, flush} !== exp_v) begin failures++; $display("FAIL arst_pre_flush got=%h exp=%h", flush, exp_v); end
        rst = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'h0040_0000); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        checks++; exp_v = exp_q.pop_front();
        if ({31'd0, flush} !== exp_v) begin failures++; $display("FAIL arst_flush got=%h exp=%h", flush, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (status !== exp_v) begin failures++; $display("FAIL arst_status got=%h exp=%h", status, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (cp0_rdata !== exp_v) begin failures++; $display("FAIL arst_count got=%h exp=%h", cp0_rdata, exp_v); end
        checks++; exp_v = exp_q.pop_front();
        if (epc !== exp_v) begin failures++; $display("FAIL arst_epc got=%h exp=%h", epc, exp_v); end
        step();
        clear_inputs();
        rst = 1'b0;
        exp_q.push_back(32'd1);
        step(); step();
        checks++; exp_v = exp_q.pop_front();
        if (cp0_rdata !== exp_v) begin failures++; $display("FAIL arst_resume_count got=%h exp=%h", cp0_rdata, exp_v); end
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_break_eret();
        test_priority();
        test_ades_mtc0();
        test_back_to_back();
        test_mtc0_rw();
        test_timer();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
